// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding a single fifo write port, with burst-limited ownership.
// Define FIFO_WR_ARB_FORMAL_EN to compile in assertions and cover points.
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DW-1:0]         req_data,
    output logic [NREQ-1:0]            gnt,
    output logic                       fifo_wen,
    output logic [DW-1:0]              fifo_wdata,
    input  logic                       fifo_ren,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_OWN  = 1'b1;

    logic          state, state_nxt;
    logic [PW-1:0] owner, owner_nxt;
    logic [PW-1:0] rr_ptr, rr_ptr_nxt;
    logic [3:0]    cnt, cnt_nxt;

    logic          space;
    logic          pop;
    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic [PW:0]   pick_sum;
    logic          grant_vld;
    logic [PW-1:0] grant_idx;
    logic [DW-1:0] wdata_sel;

    assign space = (level < LW'(DEPTH));
    assign full  = (level == LW'(DEPTH));
    assign pop   = fifo_ren && (level != '0);

    // Scan downward so the last hit is the requester closest at/after rr_ptr.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pick_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (pick_sum >= (PW+1)'(NREQ))
                pick_sum = pick_sum - (PW+1)'(NREQ);
            if (req[pick_sum[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = pick_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = cnt;
        grant_vld  = 1'b0;
        grant_idx  = owner;
        case (state)
            S_IDLE: begin
                if (pick_vld && space) begin
                    grant_vld = 1'b1;
                    grant_idx = pick_idx;
                    owner_nxt = pick_idx;
                    cnt_nxt   = 4'd1;
                    state_nxt = S_OWN;
                end
            end
            S_OWN: begin
                // Release wins over a full fifo so a stalled owner still yields the turn.
                if (!req[owner] || cnt == 4'(BURST)) begin
                    state_nxt  = S_IDLE;
                    cnt_nxt    = 4'd0;
                    rr_ptr_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end else if (space) begin
                    grant_vld = 1'b1;
                    grant_idx = owner;
                    cnt_nxt   = cnt + 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst)
            grant_vld = 1'b0;
    end

    always_comb begin
        gnt = '0;
        if (grant_vld)
            gnt[grant_idx] = 1'b1;
    end

    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant_idx == PW'(i))
                wdata_sel = req_data[i*DW +: DW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wen   <= 1'b0;
            fifo_wdata <= '0;
        end else begin
            fifo_wen <= grant_vld;
            if (grant_vld)
                fifo_wdata <= wdata_sel;
        end
    end

    // A grant only happens below DEPTH, so the increment can never overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({grant_vld, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_FORMAL_EN
    always_comb begin
        if (!rst) begin
            assert ($onehot0(gnt));
            assert (!(full && (gnt != '0)));
            assert (level <= LW'(DEPTH));
        end
    end

    assert property (@(posedge clk) disable iff (rst) fifo_wen |-> $past(gnt != '0));
    assert property (@(posedge clk) disable iff (rst) (state == S_OWN) |-> (cnt <= 4'(BURST)));

    cover property (@(posedge clk) disable iff (rst) full);
    cover property (@(posedge clk) disable iff (rst) (state == S_OWN) && (cnt == 4'(BURST)));
`else
`endif

endmodule
